// File: rtl/patdet_pkg.sv
// Shared types and constants for the serial pattern detector.
// Optional per-bit compare mask is enabled by defining PATDET_MASK_EN.
package patdet_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } patdet_state_t;

    // Encoding presented on state_o
    localparam logic [STATE_W-1:0] STATE_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] STATE_FILL  = 2'd1;
    localparam logic [STATE_W-1:0] STATE_ARMED = 2'd2;

    localparam int unsigned PAT_W_MIN = 1;
    localparam int unsigned PAT_W_MAX = 16;

    // Width of a counter that must hold 0..pat_w inclusive
    function automatic int unsigned fill_width(input int unsigned pat_w);
        return (pat_w < 1) ? 1 : $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/pattern_detector_if.sv
// Control/data/status bundle between the stimulus logic and the pattern detector.
// Carries the mask field only when PATDET_MASK_EN is defined.
interface pattern_detector_if
    import patdet_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) ();

    localparam int unsigned FILL_W = fill_width(PAT_W);

    logic              load;
    logic [PAT_W-1:0]  pattern;
`ifdef PATDET_MASK_EN
    logic [PAT_W-1:0]  mask;
`endif
    logic              overlap;
    logic              in_valid;
    logic              in_bit;
    logic              clr_count;

    logic              match;
    logic [CNT_W-1:0]  match_count;
    logic [STATE_W-1:0] state_o;
    logic [FILL_W-1:0] fill;

    modport master (
        output load,
        output pattern,
`ifdef PATDET_MASK_EN
        output mask,
`endif
        output overlap,
        output in_valid,
        output in_bit,
        output clr_count,
        input  match,
        input  match_count,
        input  state_o,
        input  fill
    );

    modport slave (
        input  load,
        input  pattern,
`ifdef PATDET_MASK_EN
        input  mask,
`endif
        input  overlap,
        input  in_valid,
        input  in_bit,
        input  clr_count,
        output match,
        output match_count,
        output state_o,
        output fill
    );

endinterface

// File: rtl/patdet_cmp.sv
// Combinational compare of the candidate history against the latched pattern.
// With PATDET_MASK_EN a mask bit of 0 turns that position into a don't-care.
module patdet_cmp #(
    parameter int unsigned PAT_W = 4
) (
    input  logic [PAT_W-1:0] history,
    input  logic [PAT_W-1:0] pattern,
`ifdef PATDET_MASK_EN
    input  logic [PAT_W-1:0] mask,
`endif
    output logic             hit
);

`ifdef PATDET_MASK_EN
    assign hit = ((history ^ pattern) & mask) == '0;
`else
    assign hit = (history == pattern);
`endif

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: shift register, IDLE/FILL/ARMED FSM and saturating match counter.
// Define PATDET_MASK_EN to add a latched don't-care mask to the compare.
module pattern_detector
    import patdet_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk_2,
    input  logic               reset,
    pattern_detector_if.slave  bus
);

    localparam int unsigned       FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    patdet_state_t     state, state_n;
    logic [PAT_W-1:0]  pattern_q, pattern_n;
    logic [PAT_W-1:0]  history, history_n;
    logic [PAT_W-1:0]  shifted;
`ifdef PATDET_MASK_EN
    logic [PAT_W-1:0]  mask_q, mask_n;
`endif
    logic [FILL_W-1:0] fill_q, fill_n, fill_inc;
    logic              match_q, match_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              hit;

    // Newest bit enters at bit 0; the oldest falls off the top
    assign shifted  = PAT_W'({history, bus.in_bit});
    assign fill_inc = fill_q + FILL_W'(1);

    patdet_cmp #(
        .PAT_W   (PAT_W)
    ) u_cmp (
        .history (shifted),
        .pattern (pattern_q),
`ifdef PATDET_MASK_EN
        .mask    (mask_q),
`endif
        .hit     (hit)
    );

    // State register
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath and counter update
    always_comb begin
        state_n   = state;
        pattern_n = pattern_q;
        history_n = history;
        fill_n    = fill_q;
        match_n   = 1'b0;
        count_n   = count_q;
`ifdef PATDET_MASK_EN
        mask_n    = mask_q;
`endif

        if (bus.load) begin
            pattern_n = bus.pattern;
`ifdef PATDET_MASK_EN
            mask_n    = bus.mask;
`endif
            history_n = '0;
            fill_n    = '0;
            state_n   = FILL;
        end else begin
            case (state)
                FILL, ARMED: begin
                    if (bus.in_valid) begin
                        history_n = shifted;
                        if (state == FILL) begin
                            fill_n = fill_inc;
                        end
                        // The beat that completes the history is compared immediately
                        if ((state == ARMED) || (fill_inc == FILL_FULL)) begin
                            state_n = ARMED;
                            if (hit) begin
                                match_n = 1'b1;
                                if (!bus.overlap) begin
                                    history_n = '0;
                                    fill_n    = '0;
                                    state_n   = FILL;
                                end
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        if (match_n && (count_q != CNT_MAX)) begin
            count_n = count_q + CNT_W'(1);
        end
        // Clear wins over a coincident increment
        if (bus.clr_count) begin
            count_n = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_2) begin
        if (reset) begin
            pattern_q <= '0;
            history   <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
`ifdef PATDET_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            pattern_q <= pattern_n;
            history   <= history_n;
            fill_q    <= fill_n;
            match_q   <= match_n;
            count_q   <= count_n;
`ifdef PATDET_MASK_EN
            mask_q    <= mask_n;
`endif
        end
    end

    assign bus.match       = match_q;
    assign bus.match_count = count_q;
    assign bus.state_o     = STATE_W'(state);
    assign bus.fill        = fill_q;

endmodule
